// File: rtl/wb_regfile_pkg.sv
// Shared writeback-stage constants: control bit positions, datapath widths
// and the hardwired zero register index.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam int CTRL_WB_REGWRITE = 1;
  localparam int CTRL_WB_MEMTOREG = 0;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_core.sv
// Raw register storage: asynchronous clear, one write port and two
// unqualified combinational read ports.
module regfile_core #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Storage array: cleared on reset, one write per edge when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects load/ALU data, commits it to the register file,
// bypasses same-cycle writes to the read ports and counts retired writes.
module wb_regfile #(
  parameter int DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W   = wb_regfile_pkg::ADDR_W,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        control_wb_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [ADDR_W-1:0] write_reg_in,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_reg,
  output logic [CNT_W-1:0]  wb_count
);

  import wb_regfile_pkg::*;

  logic              reg_write;
  logic              mem_to_reg;
  logic [DATA_W-1:0] raw1;
  logic [DATA_W-1:0] raw2;
  logic [CNT_W-1:0]  count;

  assign reg_write  = control_wb_in[CTRL_WB_REGWRITE];
  assign mem_to_reg = control_wb_in[CTRL_WB_MEMTOREG];
  assign wb_data    = mem_to_reg ? read_data_in : alu_result_in;
  assign wb_we      = reg_write && (write_reg_in != ADDR_W'(REG_ZERO));
  assign wb_reg     = write_reg_in;
  assign wb_count   = count;

  regfile_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .we    (wb_we),
    .waddr (write_reg_in),
    .wdata (wb_data),
    .raddr1(read_reg1),
    .raddr2(read_reg2),
    .rdata1(raw1),
    .rdata2(raw2)
  );

  // Read port 1: reset forces zero, r0 is hardwired, then bypass, then storage.
  always_comb begin
    read_data1 = '0;
    if (!reset) begin
      read_data1 = '0;
    end else if (read_reg1 == ADDR_W'(REG_ZERO)) begin
      read_data1 = '0;
    end else if (wb_we && (read_reg1 == write_reg_in)) begin
      read_data1 = wb_data;
    end else begin
      read_data1 = raw1;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    read_data2 = '0;
    if (!reset) begin
      read_data2 = '0;
    end else if (read_reg2 == ADDR_W'(REG_ZERO)) begin
      read_data2 = '0;
    end else if (wb_we && (read_reg2 == write_reg_in)) begin
      read_data2 = wb_data;
    end else begin
      read_data2 = raw2;
    end
  end

  // Retired-write counter; wraps freely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (wb_we) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile against an array-based model;
// a second instance with a 3-bit counter exercises counter wrap-around.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  control_wb_in = 2'b00;
  logic [31:0] read_data_in = 32'd0;
  logic [31:0] alu_result_in = 32'd0;
  logic [4:0]  write_reg_in = 5'd0;
  logic [4:0]  read_reg1 = 5'd0;
  logic [4:0]  read_reg2 = 5'd0;
  logic [31:0] read_data1, read_data2, wb_data;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_count;
  logic [31:0] s_rd1, s_rd2, s_wbd;
  logic        s_we;
  logic [4:0]  s_reg;
  logic [2:0]  s_count;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .control_wb_in(control_wb_in),
    .read_data_in(read_data_in), .alu_result_in(alu_result_in),
    .write_reg_in(write_reg_in), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2), .wb_data(wb_data),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_count(wb_count)
  );

  wb_regfile #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .control_wb_in(control_wb_in),
    .read_data_in(read_data_in), .alu_result_in(alu_result_in),
    .write_reg_in(write_reg_in), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(s_rd1), .read_data2(s_rd2), .wb_data(s_wbd),
    .wb_we(s_we), .wb_reg(s_reg), .wb_count(s_count)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wbd;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] cnt;
    logic [2:0]  cnt_small;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_regs [32];
  logic [31:0] model_count = 32'd0;
  int          rnd_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx, input bit in_reset,
                                             input bit we, input logic [4:0] wr,
                                             input logic [31:0] wbd);
    if (in_reset || idx == 5'd0) return 32'd0;
    if (we && idx == wr) return wbd;
    return model_regs[idx];
  endfunction

  // Issue one cycle of stimulus, queue its expected response, then advance the model.
  task automatic drive(input logic [1:0] c, input logic [31:0] rdi, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [4:0] a1, input logic [4:0] a2,
                       input bit rst_low, input bit kill);
    exp_t e;
    bit we;
    logic [31:0] wbd;
    @(posedge clk);
    #2;
    control_wb_in = c; read_data_in = rdi; alu_result_in = alu;
    write_reg_in = wr; read_reg1 = a1; read_reg2 = a2;
    reset = rst_low ? 1'b0 : 1'b1;
    we  = c[1] && (wr != 5'd0);
    wbd = c[0] ? rdi : alu;
    if (rst_low) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
    end
    e.rd1 = model_read(a1, rst_low, we, wr, wbd);
    e.rd2 = model_read(a2, rst_low, we, wr, wbd);
    e.wbd = wbd;
    e.we = we;
    e.wreg = wr;
    e.cnt = model_count;
    e.cnt_small = model_count[2:0];
    q.push_back(e);
    if (kill) begin
      #4;
      reset = 1'b0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      model_count = 32'd0;
    end else if (!rst_low && we) begin
      model_regs[wr] = wbd;
      model_count = model_count + 32'd1;
    end
  endtask

  // Monitor: compare every presented cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("read_data1", read_data1, e.rd1);
      chk("read_data2", read_data2, e.rd2);
      chk("wb_data", wb_data, e.wbd);
      chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
      chk("wb_reg", {27'd0, wb_reg}, {27'd0, e.wreg});
      chk("wb_count", wb_count, e.cnt);
      chk("wb_count_wrap", {29'd0, s_count}, {29'd0, e.cnt_small});
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

    for (int i = 0; i < 6; i++)
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom),
            5'($urandom), 5'($urandom), 1'b1, 1'b0);
    for (int i = 1; i < 32; i++)
      drive(2'b00, 32'd0, 32'd0, 5'd0, 5'(i), 5'(32 - i), 1'b0, 1'b0);

    drive(2'b10, 32'd0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0);
    drive(2'b11, 32'h12345678, 32'hFFFFFFFF, 5'd31, 5'd31, 5'd5, 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd31, 5'd31, 1'b0, 1'b0);
    drive(2'b10, 32'd0, 32'hAAAA5555, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive(2'b10, 32'd0, 32'h00000777, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0);
    drive(2'b01, 32'h00000055, 32'd0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rnd_wr = $urandom_range(0, 31);
      drive(2'($urandom_range(0, 3)), $urandom, $urandom, 5'(rnd_wr),
            ($urandom_range(0, 1) == 0) ? 5'(rnd_wr) : 5'($urandom),
            ($urandom_range(0, 1) == 0) ? 5'(rnd_wr) : 5'($urandom), 1'b0, 1'b0);
    end

    drive(2'b10, 32'd0, 32'h0BADF00D, 5'd9, 5'd9, 5'd31, 1'b0, 1'b1);
    drive(2'b10, 32'd0, 32'h11111111, 5'd9, 5'd9, 5'd5, 1'b1, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd9, 5'd31, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      drive(2'b10, 32'd0, $urandom, 5'(i + 1), 5'(i + 1), 5'(i), 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 5'd0, 5'd3, 5'd10, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never compared", q.size());
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if ($isunknown(dut.u_core.mem[i])) begin
        failures++;
        $display("FAIL no_x_regs: r%0d holds unknown value %h", i, dut.u_core.mem[i]);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback data (load data or ALU result) and commits it to a 32x32 general-purpose register file.
- Provides two read ports to decode, with same-cycle write-through bypass.
- Exports the committed writeback value to the forwarding unit, plus a retired-write counter for debug and performance use.

Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width
- NUM_REGS, 32, number of architectural registers (2**ADDR_W)
- CNT_W, 32, width of the retired-write counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-low (reset asserted when 0)
- control_wb_in  in  2  bit1 = RegWrite, bit0 = MemtoReg
- read_data_in  in  DATA_W  load data from MEM/WB
- alu_result_in  in  DATA_W  ALU result from MEM/WB
- write_reg_in  in  ADDR_W  destination register index
- read_reg1  in  ADDR_W  read port 1 index
- read_reg2  in  ADDR_W  read port 2 index
- read_data1  out  DATA_W  read port 1 data
- read_data2  out  DATA_W  read port 2 data
- wb_data  out  DATA_W  selected writeback value (combinational)
- wb_we  out  1  effective write enable: RegWrite and write_reg_in != 0
- wb_reg  out  ADDR_W  equals write_reg_in
- wb_count  out  CNT_W  number of committed register writes

Behaviour:
- Reset (reset == 0, asynchronous):
  - All registers clear to 0.
  - wb_count clears to 0.
  - While reset is held, read_data1 and read_data2 return 0 for every index, and bypass is disabled.
  - If reset asserts mid-cycle, a pending write is discarded.
  - Release is synchronous to the next rising edge; the first write can commit on the first rising edge after reset goes to 1.
- Writeback select (combinational):
  - wb_data = read_data_in when MemtoReg = 1; otherwise alu_result_in.
- Effective write enable:
  - wb_we = RegWrite and write_reg_in != 0.
  - Register 0 is hardwired to zero; writes to it are dropped and are not counted.
- Commit: on a rising clk edge with wb_we = 1, regs[write_reg_in] <= wb_data and wb_count <= wb_count + 1.
  - Write latency is one edge.
- Read ports are combinational, with this priority:
  - Index 0 returns 0.
  - Otherwise, if wb_we = 1 and the index equals write_reg_in, return wb_data (write-through bypass, so decode sees a value committed in the same cycle).
  - Otherwise return regs[index].
- Both ports may read the same index, including the bypassed one; both return the identical value.
- wb_count wraps modulo 2**CNT_W with no saturation and no flag.
- RegWrite = 0 with MemtoReg = 1 performs no write. wb_data still reflects read_data_in.
- Inputs are sampled only at the clock edge. No internal pipelining: a MEM/WB update arriving at the same edge as a commit is handled by the upstream register, not by this block.
- X on control_wb_in while reset == 0 is a bench error. The bench must assert that no X reaches regs.

Decomposition:
- Shared pipeline package holds:
  - Constants CTRL_WB_REGWRITE = 1 and CTRL_WB_MEMTOREG = 0 (bit positions).
  - DATA_W and ADDR_W.
  - REG_ZERO = 0.
- One sub-module: regfile_core, which holds the storage array, reset clear, write port and two raw read ports.
- wb_regfile wraps regfile_core and adds the writeback mux, zero-register masking, bypass and counter.

Test Plan:
- Reset: hold reset = 0 with random inputs, then release. Required: reads of r1..r31 return 0 and wb_count = 0.
- ALU write and bypass: control = 2'b10, alu_result_in = 0xDEADBEEF, write_reg_in = 5, read_reg1 = 5.
  - Same cycle: read_data1 = 0xDEADBEEF (bypass).
  - After the edge, with control = 00: read_data1 = 0xDEADBEEF and wb_count = 1.
- Load select: control = 2'b11, read_data_in = 0x12345678, alu_result_in = 0xFFFFFFFF, write_reg_in = 31. Required: r31 = 0x12345678 and wb_data = 0x12345678.
- Zero register: control = 2'b10, write_reg_in = 0, alu_result_in = 0xAAAA5555. Required: wb_we = 0, read_data1 for index 0 = 0, wb_count unchanged.
- No-write: control = 2'b01, write_reg_in = 7, read_data_in = 0x55. Required: r7 keeps its prior value, wb_count unchanged, and read_reg2 = 7 shows the old value with no bypass.
- Reset mid-operation and wrap:
  - Assert reset between edges while a write is pending. Required: r and wb_count are 0 and the write is lost.
  - Force wb_count to 0xFFFFFFFF, then commit one write. Required: wb_count = 0.
